// File: rtl/axi4_arbiter_2to1.sv
// Two-master round-robin arbiter in front of one AXI4 slave port.
// Optional AXI4_ARBITER_WLAST_GEN_EN: generate s_wlast from an awlen beat counter.
module axi4_arbiter_2to1 #(
    parameter int A_WIDTH = 26,
    parameter int D_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [1:0]             m_awvalid,
    input  logic [2*A_WIDTH-1:0]   m_awaddr,
    input  logic [15:0]            m_awlen,
    output logic [1:0]             m_awready,
    input  logic [1:0]             m_wvalid,
    input  logic [1:0]             m_wlast,
    input  logic [2*D_WIDTH-1:0]   m_wdata,
    output logic [1:0]             m_wready,
    output logic [1:0]             m_bvalid,
    input  logic [1:0]             m_bready,
    input  logic [1:0]             m_arvalid,
    input  logic [2*A_WIDTH-1:0]   m_araddr,
    input  logic [15:0]            m_arlen,
    output logic [1:0]             m_arready,
    output logic [1:0]             m_rvalid,
    output logic [1:0]             m_rlast,
    output logic [D_WIDTH-1:0]     m_rdata,
    input  logic [1:0]             m_rready,
    output logic                   s_awvalid,
    output logic [A_WIDTH-1:0]     s_awaddr,
    output logic [7:0]             s_awlen,
    input  logic                   s_awready,
    output logic                   s_wvalid,
    output logic                   s_wlast,
    output logic [D_WIDTH-1:0]     s_wdata,
    input  logic                   s_wready,
    input  logic                   s_bvalid,
    output logic                   s_bready,
    output logic                   s_arvalid,
    output logic [A_WIDTH-1:0]     s_araddr,
    output logic [7:0]             s_arlen,
    input  logic                   s_arready,
    input  logic                   s_rvalid,
    input  logic                   s_rlast,
    input  logic [D_WIDTH-1:0]     s_rdata,
    output logic                   s_rready,
    output logic                   busy,
    output logic                   grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   prio_q, prio_d;
    logic [1:0] req;
    logic   sel;
    logic   wlast_g;

`ifdef AXI4_ARBITER_WLAST_GEN_EN
    logic [7:0] cnt_q, cnt_d;
    logic       wlast_unused;
    assign wlast_unused = ^m_wlast;
    assign wlast_g = (cnt_q == 8'd0);
`else
    assign wlast_g = m_wlast[grant_q];
`endif

    assign req = m_arvalid | m_awvalid;
    assign sel = (req == 2'b11) ? prio_q : req[1];

    assign s_araddr = grant_q ? m_araddr[2*A_WIDTH-1:A_WIDTH]
                              : m_araddr[A_WIDTH-1:0];
    assign s_arlen  = grant_q ? m_arlen[15:8] : m_arlen[7:0];
    assign s_awaddr = grant_q ? m_awaddr[2*A_WIDTH-1:A_WIDTH]
                              : m_awaddr[A_WIDTH-1:0];
    assign s_awlen  = grant_q ? m_awlen[15:8] : m_awlen[7:0];
    assign s_wdata  = grant_q ? m_wdata[2*D_WIDTH-1:D_WIDTH]
                              : m_wdata[D_WIDTH-1:0];
    assign m_rdata  = s_rdata;

    assign busy  = (state_q != S_IDLE);
    assign grant = grant_q;

    // Next state, arbitration and channel routing to the granted master
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        s_rready  = 1'b0;
        s_bready  = 1'b0;
        m_arready = 2'b00;
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_rvalid  = 2'b00;
        m_rlast   = 2'b00;
        m_bvalid  = 2'b00;
`ifdef AXI4_ARBITER_WLAST_GEN_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = sel;
                    state_d = m_arvalid[sel] ? S_AR : S_AW;
                end
            end
            S_AR: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
                if (m_arvalid[grant_q] && s_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                m_rvalid[grant_q] = s_rvalid;
                m_rlast[grant_q]  = s_rlast;
                s_rready          = m_rready[grant_q];
                if (s_rvalid && m_rready[grant_q] && s_rlast) begin
                    state_d = S_IDLE;
                    prio_d  = ~grant_q;
                end
            end
            S_AW: begin
                s_awvalid          = m_awvalid[grant_q];
                m_awready[grant_q] = s_awready;
                if (m_awvalid[grant_q] && s_awready) begin
                    state_d = S_W;
`ifdef AXI4_ARBITER_WLAST_GEN_EN
                    cnt_d   = s_awlen;
`endif
                end
            end
            S_W: begin
                s_wvalid          = m_wvalid[grant_q];
                s_wlast           = wlast_g;
                m_wready[grant_q] = s_wready;
                if (m_wvalid[grant_q] && s_wready) begin
`ifdef AXI4_ARBITER_WLAST_GEN_EN
                    cnt_d = cnt_q - 8'd1;
`endif
                    if (wlast_g) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                m_bvalid[grant_q] = s_bvalid;
                s_bready          = m_bready[grant_q];
                if (s_bvalid && m_bready[grant_q]) begin
                    state_d = S_IDLE;
                    prio_d  = ~grant_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

`ifdef AXI4_ARBITER_WLAST_GEN_EN
    // Write beat counter, loaded from awlen on the AW handshake
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_arbiter_2to1.sv
// Scoreboard bench for axi4_arbiter_2to1.
// Drives both masters and a scripted slave; R/W beats go through queues.
module tb_axi4_arbiter_2to1;

    localparam int AW = 26;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [1:0]      m_awvalid, m_awready;
    logic [2*AW-1:0] m_awaddr;
    logic [15:0]     m_awlen;
    logic [1:0]      m_wvalid, m_wlast, m_wready;
    logic [2*DW-1:0] m_wdata;
    logic [1:0]      m_bvalid, m_bready;
    logic [1:0]      m_arvalid, m_arready;
    logic [2*AW-1:0] m_araddr;
    logic [15:0]     m_arlen;
    logic [1:0]      m_rvalid, m_rlast, m_rready;
    logic [DW-1:0]   m_rdata;
    logic            s_awvalid, s_awready;
    logic [AW-1:0]   s_awaddr;
    logic [7:0]      s_awlen;
    logic            s_wvalid, s_wlast, s_wready;
    logic [DW-1:0]   s_wdata;
    logic            s_bvalid, s_bready;
    logic            s_arvalid, s_arready;
    logic [AW-1:0]   s_araddr;
    logic [7:0]      s_arlen;
    logic            s_rvalid, s_rlast, s_rready;
    logic [DW-1:0]   s_rdata;
    logic            busy, grant;

    int n_chk = 0;
    int n_err = 0;
    int rv_cnt [2];
    logic [16:0] rq [$];
    logic [16:0] wq [$];
    logic [17:0] outv;

    axi4_arbiter_2to1 #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast),
        .m_wdata(m_wdata), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_rdata(m_rdata), .m_rready(m_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast),
        .s_wdata(s_wdata), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rlast(s_rlast),
        .s_rdata(s_rdata), .s_rready(s_rready),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    assign outv = {s_arvalid, s_awvalid, s_wvalid, s_rready,
                   s_bready, s_wlast, m_arready, m_awready,
                   m_wready, m_rvalid, m_bvalid, busy, grant};

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat monitor: pops expected R and W beats on each handshake
    always @(negedge clk) begin : mon
        logic [16:0] e;
        for (int k = 0; k < 2; k++) begin
            if (m_rvalid[k] === 1'b1) begin
                rv_cnt[k]++;
                chk("rv_grant", grant, k);
                if (m_rready[k] === 1'b1) begin
                    if (rq.size() == 0) chk("r_unexp", 1, 0);
                    else begin
                        e = rq.pop_front();
                        chk("rbeat", {m_rlast[k], m_rdata}, e);
                    end
                end
            end
        end
        if (s_wvalid === 1'b1 && s_wready === 1'b1) begin
            if (wq.size() == 0) chk("w_unexp", 1, 0);
            else begin
                e = wq.pop_front();
                chk("wbeat", {s_wlast, s_wdata}, e);
            end
        end
    end

    task automatic set_ar(input int i, input logic [AW-1:0] a,
                          input logic [7:0] l);
        m_arvalid[i] = 1'b1;
        m_araddr[i*AW +: AW] = a;
        m_arlen[i*8 +: 8] = l;
    endtask

    task automatic set_aw(input int i, input logic [AW-1:0] a,
                          input logic [7:0] l);
        m_awvalid[i] = 1'b1;
        m_awaddr[i*AW +: AW] = a;
        m_awlen[i*8 +: 8] = l;
    endtask

    task automatic wait_ar(input int i, input logic [AW-1:0] a,
                           input logic [7:0] l);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(s_arvalid && s_arready) && t < 20);
        chk("ar_hs", s_arvalid && s_arready, 1);
        chk("ar_grant", grant, i);
        chk("araddr", s_araddr, a);
        chk("arlen", s_arlen, l);
        chk("arready", m_arready, 64'd1 << i);
        chk("ar_no_aw", s_awvalid, 0);
        @(posedge clk);
        #1;
        m_arvalid[i] = 1'b0;
    endtask

    task automatic wait_aw(input int i, input logic [AW-1:0] a,
                           input logic [7:0] l);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(s_awvalid && s_awready) && t < 20);
        chk("aw_hs", s_awvalid && s_awready, 1);
        chk("aw_grant", grant, i);
        chk("awaddr", s_awaddr, a);
        chk("awlen", s_awlen, l);
        chk("awready", m_awready, 64'd1 << i);
        chk("aw_no_ar", s_arvalid, 0);
        @(posedge clk);
        #1;
        m_awvalid[i] = 1'b0;
    endtask

    task automatic serve_r(input int i, input int n,
                           input logic [DW-1:0] base);
        int t;
        for (int b = 0; b < n; b++) begin
            s_rvalid = 1'b1;
            s_rdata = base + DW'(b);
            s_rlast = (b == n - 1);
            m_rready[i] = 1'b1;
            rq.push_back({s_rlast, s_rdata});
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(s_rvalid && s_rready) && t < 20);
            chk("r_hs", s_rvalid && s_rready, 1);
            @(posedge clk);
            #1;
        end
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        m_rready[i] = 1'b0;
    endtask

    task automatic serve_w(input int i, input int n,
                           input logic [DW-1:0] base,
                           input logic [DW-1:0] step,
                           input int len, input bit tog,
                           input bit hold0);
        int c = 0;
        int t;
        bit hs;
        logic el;
        logic [DW-1:0] d;
        for (int b = 0; b < n; b++) begin
            d = base + DW'(b) * step;
            m_wvalid[i] = 1'b1;
            m_wdata[i*DW +: DW] = d;
            m_wlast[i] = hold0 ? 1'b0 : (b == n - 1);
`ifdef AXI4_ARBITER_WLAST_GEN_EN
            el = (b == len);
`else
            el = m_wlast[i];
`endif
            wq.push_back({el, d});
            t = 0;
            hs = 0;
            while (!hs && t < 20) begin
                s_wready = tog ? (c % 2 == 0) : 1'b1;
                c++;
                t++;
                @(negedge clk);
                hs = s_wvalid && s_wready;
                if (!hs) begin
                    @(posedge clk);
                    #1;
                end
            end
            chk("w_hs", hs, 1);
            chk("wready", m_wready, 64'd1 << i);
            @(posedge clk);
            #1;
        end
        m_wvalid[i] = 1'b0;
        m_wlast[i] = 1'b0;
        s_wready = 1'b1;
    endtask

    task automatic serve_b(input int i);
        s_bvalid = 1'b1;
        m_bready[i] = 1'b1;
        @(negedge clk);
        chk("bvalid", m_bvalid, 64'd1 << i);
        chk("bready", s_bready, 1);
        @(posedge clk);
        #1;
        s_bvalid = 1'b0;
        m_bready[i] = 1'b0;
        @(negedge clk);
        chk("b_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        m_awvalid = '0; m_awaddr = '0; m_awlen = '0;
        m_wvalid = '0; m_wlast = '0; m_wdata = '0;
        m_bready = '0; m_arvalid = '0; m_araddr = '0;
        m_arlen = '0; m_rready = '0;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_rdata = '0;
        rv_cnt[0] = 0;
        rv_cnt[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", outv, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // single read from m0
        rv_cnt[0] = 0;
        rv_cnt[1] = 0;
        set_ar(0, 26'h0000100, 8'd3);
        wait_ar(0, 26'h0000100, 8'd3);
        serve_r(0, 4, 16'h00A0);
        @(negedge clk);
        chk("rd_idle", busy, 0);
        chk("rv0_cnt", rv_cnt[0], 4);
        chk("rv1_cnt", rv_cnt[1], 0);

        // prio now favours m1
        @(posedge clk);
        #1;
        set_ar(0, 26'h0000200, 8'd0);
        set_ar(1, 26'h0000300, 8'd0);
        wait_ar(1, 26'h0000300, 8'd0);
        serve_r(1, 1, 16'h00B0);
        @(negedge clk);
        chk("gap_busy", busy, 0);
        chk("gap_arv", s_arvalid, 0);
        wait_ar(0, 26'h0000200, 8'd0);
        serve_r(0, 1, 16'h00C0);

        // write burst from m1 with wready toggling
        set_aw(1, 26'h0000020, 8'd1);
        wait_aw(1, 26'h0000020, 8'd1);
        serve_w(1, 2, 16'h1234, 16'h4444, 1, 1'b1, 1'b0);
        serve_b(1);

        // prio back to m0
        set_ar(0, 26'h0000210, 8'd0);
        set_ar(1, 26'h0000310, 8'd0);
        wait_ar(0, 26'h0000210, 8'd0);
        serve_r(0, 1, 16'h00C8);
        wait_ar(1, 26'h0000310, 8'd0);
        serve_r(1, 1, 16'h00B8);

        // same master with ar and aw: read first
        set_ar(0, 26'h0000400, 8'd1);
        set_aw(0, 26'h0000500, 8'd0);
        wait_ar(0, 26'h0000400, 8'd1);
        serve_r(0, 2, 16'h00D0);
        @(negedge clk);
        chk("rw_idle", busy, 0);
        chk("rw_awv", s_awvalid, 0);
        wait_aw(0, 26'h0000500, 8'd0);
        serve_w(0, 1, 16'h00E0, 16'h0000, 0, 1'b0, 1'b0);
        serve_b(0);

        // reset during the second beat of an 8-beat read
        set_ar(1, 26'h0000600, 8'd7);
        wait_ar(1, 26'h0000600, 8'd7);
        s_rvalid = 1'b1;
        s_rdata = 16'h00F0;
        s_rlast = 1'b0;
        m_rready[1] = 1'b1;
        rq.push_back({1'b0, 16'h00F0});
        @(negedge clk);
        @(posedge clk);
        #1;
        s_rdata = 16'h00F1;
        rq.push_back({1'b0, 16'h00F1});
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_outs", outv, 0);
        @(posedge clk);
        #1;
        s_rvalid = 1'b0;
        m_rready[1] = 1'b0;
        rstn = 1'b1;

        // after reset both requesting: m0 first
        set_ar(0, 26'h0000220, 8'd0);
        set_ar(1, 26'h0000320, 8'd0);
        wait_ar(0, 26'h0000220, 8'd0);
        serve_r(0, 1, 16'h0011);
        wait_ar(1, 26'h0000320, 8'd0);
        serve_r(1, 1, 16'h0022);

        // awlen=2 with master wlast held low
        set_aw(0, 26'h0000700, 8'd2);
        wait_aw(0, 26'h0000700, 8'd2);
        serve_w(0, 3, 16'h1000, 16'h0001, 2, 1'b0, 1'b1);
`ifdef AXI4_ARBITER_WLAST_GEN_EN
        serve_b(0);
`else
        s_bvalid = 1'b1;
        m_bready[0] = 1'b1;
        @(negedge clk);
        chk("stay_w_b", m_bvalid, 0);
        chk("stay_w_busy", busy, 1);
        chk("stay_w_rdy", m_wready, 1);
        @(posedge clk);
        #1;
        s_bvalid = 1'b0;
        m_bready[0] = 1'b0;
        serve_w(0, 1, 16'h2000, 16'h0000, 0, 1'b0, 1'b0);
        serve_b(0);
`endif

        @(negedge clk);
        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
